data_memo: RTL and testbench
============================

Name: data_memo

Overview:
- Byte-addressed 4 KB data memory for the single-cycle MIPS CPU; serves lw/sw-style accesses.
- Reads are combinational, so load data reaches the register-file write mux in the same cycle.
- Writes commit on the rising clock edge.
- Word, halfword and byte access widths use little-endian byte lanes.

Parameters:
- ADDR_WIDTH, 12, byte-address width; memory holds 2^(ADDR_WIDTH-2) 32-bit words (1024 at default).
- INIT_ZERO, 1, when 1 every word is zero at power-up (simulation and FPGA init) as well as after reset.

Ports:
- clk  input  1  rising-edge clock for writes and reset.
- rst  input  1  synchronous, active-high reset; clears all memory.
- addr  input  ADDR_WIDTH  byte address.
- din  input  32  write data; low-order bits are used for sub-word writes.
- WE  input  1  write enable, sampled at the rising edge of clk.
- mode  input  2  access width: 00 word, 01 halfword, 10 byte, 11 word (alias of 00).
- DataOut  output  32  combinational read data.

Behaviour:
- Storage: array mem of 2^(ADDR_WIDTH-2) words, 32 bits each. Word index = addr[ADDR_WIDTH-1:2].
- Lanes (little-endian): byte k of a word = bits [8k+7:8k], selected by addr[1:0]. Halfword h = bits [16h+15:16h], selected by addr[1].
- Read is combinational from addr, mode and current memory contents; no read enable.
  - word: DataOut = mem[idx]; addr[1:0] ignored.
  - halfword: DataOut = {16'b0, selected half}; addr[0] ignored.
  - byte: DataOut = {24'b0, selected byte}.
  - All sub-word reads are zero-extended.
- Write at posedge clk when WE=1 and rst=0:
  - word: mem[idx] <= din; addr[1:0] ignored.
  - halfword: writes din[15:0] into the lane selected by addr[1]; the other half is unchanged.
  - byte: writes din[7:0] into the lane selected by addr[1:0]; other bytes are unchanged.
- Reset: at posedge clk with rst=1, every word becomes 0x00000000 in that single cycle. rst overrides WE: a write in the same cycle is discarded.
- After reset, DataOut = 0 for every address and mode.
- Read-during-write, same address: DataOut shows the old value until the edge and the new value immediately after it (no bypass).
- Address wrap: addr is exactly ADDR_WIDTH bits, so there is no out-of-range access. 0xFFC addresses the last word.
- WE=0: memory unchanged regardless of din, addr or mode.
- No X propagation: with INIT_ZERO=1, reading unwritten locations returns 0.

Optional Feature:
- Macro DATA_MEMO_DEBUG_PORT_EN adds a second, read-only display port:
  - input dbg_addr [3:0]: word index 0..15.
  - output dbg_data [31:0] = mem[dbg_addr], combinational, always full word.
- This port is independent of addr, mode and WE, and has no effect on the main port. It replaces a separate memory instance for the seven-segment display.
- Without the macro these ports do not exist and behaviour is otherwise identical.

Test Plan:
- rst=1 for one edge after arbitrary prior writes, then read addr 0x000, 0x7FC and 0xFFC in mode 00 -> DataOut = 0x00000000 at each.
- Word write din=0x12345678 to addr 0x010, mode 00, WE=1 -> before the edge DataOut=0x00000000. After the edge: mode 00 -> 0x12345678; mode 10 at addr 0x013 -> 0x00000012; mode 01 at addr 0x012 -> 0x00001234.
- Byte write din=0xFFFFFFAB to addr 0x011, mode 10, over word 0x12345678 -> word read gives 0x1234AB78 (other lanes unchanged).
- Halfword write din=0x0000BEEF to addr 0x012, mode 01 -> word read gives 0xBEEFAB78. Halfword read at 0x013 gives 0x0000BEEF (addr[0] ignored).
- Same edge with rst=1 and WE=1, din=0xDEADBEEF to addr 0x020 -> word at 0x020 reads 0x00000000 afterwards.
- With DATA_MEMO_DEBUG_PORT_EN: write 0xCAFEF00D to addr 0x00C, set dbg_addr=3 -> dbg_data=0xCAFEF00D, while the main port reads addr 0x000 as 0x00000000 unaffected.

Source files
------------

// File: rtl/data_memo_if.sv
// rtl/data_memo_if.sv - data memory access bus (address, write data, width, read data)
interface data_memo_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           din;
    logic                  WE;
    logic [1:0]            mode;
    logic [31:0]           DataOut;

    modport master (output addr, din, WE, mode, input DataOut);
    modport slave  (input addr, din, WE, mode, output DataOut);
endinterface

// File: rtl/data_memo.sv
// rtl/data_memo.sv - byte-addressed data memory, combinational little-endian reads, clocked writes
// Optional display read port enabled by DATA_MEMO_DEBUG_PORT_EN.
module data_memo #(
    parameter int ADDR_WIDTH = 12,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    data_memo_if.slave       bus
`ifdef DATA_MEMO_DEBUG_PORT_EN
    ,
    input  logic [3:0]       dbg_addr,
    output logic [31:0]      dbg_data
`endif
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 1 << IDX_W;
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 'x;

    logic [31:0]      mem_q [WORDS] = '{default: INIT_WORD};
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [31:0]      rd_data;
    logic [31:0]      wr_word_d;

    assign idx     = bus.addr[ADDR_WIDTH-1:2];
    assign lane    = bus.addr[1:0];
    assign rd_word = mem_q[idx];

    always_comb begin
        rd_data = rd_word;
        case (bus.mode)
            2'b01: rd_data = {16'h0000, lane[1] ? rd_word[31:16] : rd_word[15:0]};
            2'b10: begin
                case (lane)
                    2'd0:    rd_data = {24'h000000, rd_word[7:0]};
                    2'd1:    rd_data = {24'h000000, rd_word[15:8]};
                    2'd2:    rd_data = {24'h000000, rd_word[23:16]};
                    default: rd_data = {24'h000000, rd_word[31:24]};
                endcase
            end
            default: rd_data = rd_word;
        endcase
    end

    assign bus.DataOut = rd_data;

    // Sub-word writes merge into the current word so untouched lanes keep their value.
    always_comb begin
        wr_word_d = rd_word;
        case (bus.mode)
            2'b01: begin
                if (lane[1]) wr_word_d[31:16] = bus.din[15:0];
                else         wr_word_d[15:0]  = bus.din[15:0];
            end
            2'b10: begin
                case (lane)
                    2'd0:    wr_word_d[7:0]   = bus.din[7:0];
                    2'd1:    wr_word_d[15:8]  = bus.din[7:0];
                    2'd2:    wr_word_d[23:16] = bus.din[7:0];
                    default: wr_word_d[31:24] = bus.din[7:0];
                endcase
            end
            default: wr_word_d = bus.din;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (bus.WE) begin
            mem_q[idx] <= wr_word_d;
        end
    end

`ifdef DATA_MEMO_DEBUG_PORT_EN
    assign dbg_data = mem_q[{{(IDX_W-4){1'b0}}, dbg_addr}];
`endif

endmodule

// File: tb/tb_data_memo.sv
// tb/tb_data_memo.sv - randomized self-checking bench for data_memo against a byte-array model
module tb_data_memo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks   = 0;
    int   n_failures = 0;

    data_memo_if #(.ADDR_WIDTH(12)) bus ();

`ifdef DATA_MEMO_DEBUG_PORT_EN
    logic [3:0]  dbg_addr = 4'd0;
    logic [31:0] dbg_data;
    data_memo #(.ADDR_WIDTH(12), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );
`else
    data_memo #(.ADDR_WIDTH(12), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    logic [7:0] model_mem [4096];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int a, input logic [1:0] m);
        int w;
        int h;
        w = a & ~3;
        h = a & ~1;
        case (m)
            2'b01:   return {16'h0000, model_mem[h+1], model_mem[h]};
            2'b10:   return {24'h000000, model_mem[a]};
            default: return {model_mem[w+3], model_mem[w+2], model_mem[w+1], model_mem[w]};
        endcase
    endfunction

    task automatic model_write(input int a, input logic [1:0] m, input logic [31:0] d);
        int w;
        int h;
        w = a & ~3;
        h = a & ~1;
        case (m)
            2'b01: begin
                model_mem[h]   = d[7:0];
                model_mem[h+1] = d[15:8];
            end
            2'b10: model_mem[a] = d[7:0];
            default: begin
                model_mem[w]   = d[7:0];
                model_mem[w+1] = d[15:8];
                model_mem[w+2] = d[23:16];
                model_mem[w+3] = d[31:24];
            end
        endcase
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    endtask

    // One clock of traffic: drive at the falling edge, verify the pre-edge read, update the model at the edge.
    task automatic op(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d,
                      input logic we, input logic r);
        @(negedge clk);
        bus.addr = a;
        bus.mode = m;
        bus.din  = d;
        bus.WE   = we;
        rst      = r;
        #1;
        check("pre_edge_read", bus.DataOut, model_read(int'(a), m));
        @(posedge clk);
        if (r) model_clear();
        else if (we) model_write(int'(a), m, d);
        #1;
        bus.WE = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [1:0] m, output logic [31:0] v);
        bus.WE   = 1'b0;
        bus.addr = a;
        bus.mode = m;
        #1;
        v = bus.DataOut;
    endtask

    logic [31:0] v;

    initial begin
        bus.addr = '0;
        bus.din  = '0;
        bus.WE   = 1'b0;
        bus.mode = 2'b00;
        model_clear();

        rd(12'h000, 2'b00, v);
        check("powerup_zero", v, 32'h0);

        for (int i = 0; i < 8; i++) op(12'(i * 512 + 4), 2'b00, $urandom, 1'b1, 1'b0);
        op(12'h7FC, 2'b00, 32'hA5A5_5A5A, 1'b1, 1'b0);
        op(12'hFFC, 2'b00, 32'h1111_2222, 1'b1, 1'b0);
        op(12'h000, 2'b00, 32'h0, 1'b0, 1'b1);
        rd(12'h000, 2'b00, v); check("rst_000", v, 32'h0);
        rd(12'h7FC, 2'b00, v); check("rst_7fc", v, 32'h0);
        rd(12'hFFC, 2'b00, v); check("rst_ffc", v, 32'h0);
        rd(12'h204, 2'b10, v); check("rst_204_byte", v, 32'h0);

        op(12'h010, 2'b00, 32'h1234_5678, 1'b1, 1'b0);
        rd(12'h010, 2'b00, v); check("word_wr", v, 32'h1234_5678);
        rd(12'h013, 2'b10, v); check("byte_rd_013", v, 32'h0000_0012);
        rd(12'h012, 2'b01, v); check("half_rd_012", v, 32'h0000_1234);
        rd(12'h010, 2'b11, v); check("mode11_word", v, 32'h1234_5678);

        op(12'h011, 2'b10, 32'hFFFF_FFAB, 1'b1, 1'b0);
        rd(12'h010, 2'b00, v); check("byte_wr_merge", v, 32'h1234_AB78);

        op(12'h012, 2'b01, 32'h0000_BEEF, 1'b1, 1'b0);
        rd(12'h010, 2'b00, v); check("half_wr_merge", v, 32'hBEEF_AB78);
        rd(12'h013, 2'b01, v); check("half_rd_013", v, 32'h0000_BEEF);

        op(12'h011, 2'b00, 32'hCAFE_0001, 1'b0, 1'b0);
        rd(12'h010, 2'b00, v); check("we0_no_change", v, 32'hBEEF_AB78);

        op(12'h020, 2'b00, 32'h5555_AAAA, 1'b1, 1'b0);
        op(12'h020, 2'b00, 32'hDEAD_BEEF, 1'b1, 1'b1);
        rd(12'h020, 2'b00, v); check("rst_over_we", v, 32'h0);
        rd(12'h010, 2'b00, v); check("rst_clears_010", v, 32'h0);

`ifdef DATA_MEMO_DEBUG_PORT_EN
        op(12'h00C, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0);
        dbg_addr = 4'd3;
        rd(12'h000, 2'b00, v);
        check("dbg_word3", dbg_data, 32'hCAFE_F00D);
        check("dbg_main_indep", v, 32'h0);
`endif

        for (int n = 0; n < 600; n++) begin
            logic [11:0] a;
            a = ($urandom % 4 == 0) ? 12'($urandom % 64) : 12'($urandom);
            op(a, 2'($urandom), $urandom, 1'($urandom), ($urandom % 97 == 0));
            rd(12'($urandom), 2'($urandom), v);
            check("rand_read", v, model_read(int'(bus.addr), bus.mode));
`ifdef DATA_MEMO_DEBUG_PORT_EN
            dbg_addr = 4'($urandom);
            #1;
            check("rand_dbg", dbg_data, model_read(int'(dbg_addr) * 4, 2'b00));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule
